// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller:
// slot state encoding, active-low hex glyph table and the all-dark segment code.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous value update.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int SLOT_MAX = (TICK_DIV > BLANK_CYCLES)
                            ? ((TICK_DIV > 2) ? TICK_DIV : 2)
                            : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW = $clog2(SLOT_MAX);
    localparam logic [CW-1:0] ACT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [15:0] shadow_val_reg, shadow_val_next;
    logic [3:0]  shadow_dp_reg, shadow_dp_next;
    logic [15:0] pend_val_reg, pend_val_next;
    logic [3:0]  pend_dp_reg, pend_dp_next;
    logic        pend_flag_reg, pend_flag_next;

    logic [3:0]  an_reg, an_next;
    logic [6:0]  seg_reg, seg_next;
    logic        dp_reg, dp_next;
    logic        frame_done_reg, frame_done_next;

    logic [6:0]  dec_seg;
    logic [3:0]  lead_zero;

    // Slot sequencing
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg + 1'b1;
        case (state_reg)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_reg == BLK_LAST) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == ACT_LAST) begin
                    idx_next   = idx_reg + 2'd1;
                    cnt_next   = '0;
                    state_next = (BLANK_CYCLES == 0) ? ST_ACTIVE : ST_BLANK;
                end
            end
        endcase
        frame_done_next = (state_next == ST_ACTIVE) && (idx_next == 2'd3) && (cnt_next == ACT_LAST);
    end

    // The frame_done cycle is the only point where the displayed value may change
    always_comb begin
        shadow_val_next = shadow_val_reg;
        shadow_dp_next  = shadow_dp_reg;
        pend_val_next   = pend_val_reg;
        pend_dp_next    = pend_dp_reg;
        pend_flag_next  = pend_flag_reg;
        if (frame_done_reg) begin
            if (load) begin
                shadow_val_next = value;
                shadow_dp_next  = dp_in;
            end else if (pend_flag_reg) begin
                shadow_val_next = pend_val_reg;
                shadow_dp_next  = pend_dp_reg;
            end
            pend_flag_next = 1'b0;
        end else if (load) begin
            pend_val_next  = value;
            pend_dp_next   = dp_in;
            pend_flag_next = 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    logic [3:0] nib_zero;
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib_zero
        assign nib_zero[gi] = (shadow_val_next[4*gi +: 4] == 4'h0);
    end
    assign lead_zero = {nib_zero[3], &nib_zero[3:2], &nib_zero[3:1], 1'b0};
`else
    assign lead_zero = 4'b0000;
`endif

    seg7_decode u_decode (
        .nibble (shadow_val_next[{idx_next, 2'b00} +: 4]),
        .seg    (dec_seg)
    );

    // Outputs are computed from next state so they line up with the state register
    always_comb begin
        an_next  = 4'hF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (state_next == ST_ACTIVE) begin
            seg_next = dec_seg;
            dp_next  = ~shadow_dp_next[idx_next];
            if (digit_en[idx_next] && !lead_zero[idx_next])
                an_next[idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_BLANK;
            idx_reg        <= 2'd0;
            cnt_reg        <= '0;
            shadow_val_reg <= 16'h0000;
            shadow_dp_reg  <= 4'h0;
            pend_val_reg   <= 16'h0000;
            pend_dp_reg    <= 4'h0;
            pend_flag_reg  <= 1'b0;
            an_reg         <= 4'hF;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            shadow_val_reg <= shadow_val_next;
            shadow_dp_reg  <= shadow_dp_next;
            pend_val_reg   <= pend_val_next;
            pend_dp_reg    <= pend_dp_next;
            pend_flag_reg  <= pend_flag_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with TICK_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_ctrl #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks n cycles of a frame whose shadow is sv/sdp; optionally pulses load at cycles la/lb.
    task automatic run_frame(input logic [15:0] sv, input logic [3:0] sdp, input logic [3:0] en,
                             input int n,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] one;
        logic [15:0] sh;
        bit         dark;
        int         d;
        int         pos;
        digit_en = en;
        one = 4'b0001;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d   = i / 6;
            pos = i % 6;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if (pos >= 2) begin
                sh    = sv >> (4 * d);
                e_seg = GLYPH[sh[3:0]];
                e_dp  = ~sdp[d];
                dark  = 1'b0;
`ifdef SEG7_LZB_EN
                dark  = (d > 0) && (sh == 16'h0000);
`endif
                if (en[d] && !dark)
                    e_an = ~(one << d);
            end
            chk($sformatf("f%0d c%0d an", frame_no, i), {12'h0, an}, {12'h0, e_an});
            chk($sformatf("f%0d c%0d seg", frame_no, i), {9'h0, seg}, {9'h0, e_seg});
            chk($sformatf("f%0d c%0d dp", frame_no, i), {15'h0, dp}, {15'h0, e_dp});
            chk($sformatf("f%0d c%0d frame_done", frame_no, i), {15'h0, frame_done},
                {15'h0, (i == 23)});
            load = 1'b0;
            if (i == la) begin load = 1'b1; value = va; dp_in = da; end
            if (i == lb) begin load = 1'b1; value = vb; dp_in = db; end
        end
        $display("frame %0d: shadow=%h dp=%b en=%b cycles=%0d checks=%0d errors=%0d",
                 frame_no, sv, sdp, en, n, checks, errors);
        frame_no++;
    endtask

    initial begin
        #12;
        chk("reset an", {12'h0, an}, 16'h000F);
        chk("reset seg", {9'h0, seg}, 16'h007F);
        chk("reset dp", {15'h0, dp}, 16'h0001);
        chk("reset frame_done", {15'h0, frame_done}, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b1;

        // Shadow clear after reset; load 1234 mid-frame
        run_frame(16'h0000, 4'h0, 4'hF, 24, 5, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        run_frame(16'h1234, 4'h0, 4'hF, 24, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Digits 1 and 3 disabled; two loads mid-frame, latest wins next frame
        run_frame(16'h1234, 4'h0, 4'b0101, 24, 4, 16'hAAAA, 4'h0, 13, 16'h5555, 4'b0001);
        // Load coinciding with frame_done goes straight to shadow
        run_frame(16'h5555, 4'b0001, 4'hF, 24, 23, 16'hBEEF, 4'h0, -1, 16'h0, 4'h0);
        run_frame(16'hBEEF, 4'h0, 4'hF, 24, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Stop in digit 2 ACTIVE (cycle 14) and reset asynchronously
        run_frame(16'hBEEF, 4'h0, 4'hF, 15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        chk("pre-reset digit2 an", {12'h0, an}, 16'h000B);
        #1 rst = 1'b0;
        #1;
        chk("async reset an", {12'h0, an}, 16'h000F);
        chk("async reset seg", {9'h0, seg}, 16'h007F);
        chk("async reset dp", {15'h0, dp}, 16'h0001);
        chk("async reset frame_done", {15'h0, frame_done}, 16'h0000);
        $display("mid-slot reset applied: checks=%0d errors=%0d", checks, errors);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_frame(16'h0000, 4'h0, 4'hF, 24, 2, 16'h0007, 4'h0, -1, 16'h0, 4'h0);
        run_frame(16'h0007, 4'h0, 4'hF, 24, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
